counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter N, default 4: counter width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 start  input  1  request one run; accepted only in IDLE.
REQ-005 mode  input  1  0 = one-shot, 1 = periodic; latched on start acceptance.
REQ-006 start_val  input  N  preload value; latched on start acceptance.
REQ-007 term_val  input  N  terminal value; latched on start acceptance.
REQ-008 pause  input  1  level; suspends counting while high.
REQ-009 abort  input  1  terminates any active run.
REQ-010 q  output  N  current count.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  registered one-cycle pulse per terminal event.
REQ-013 period_cnt  output  8  terminal events since last accepted start, saturating at 255.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, RUN, HOLD and FIN.
REQ-015 IDLE: q held; start=1 with abort=0 -> latch mode/start_val/term_val, clear period_cnt, go to LOAD.
REQ-016 LOAD: counter load asserted; q <= start_val at edge; go to RUN.
REQ-017 RUN with pause=0 and q != term_val: q <= q+1 modulo 2^N (15 wraps to 0 for N=4).
REQ-018 RUN with pause=0 and q == term_val (terminal event): no increment; done <= 1 for one cycle; period_cnt +1 (saturating); go to FIN if mode=0, LOAD if mode=1.
REQ-019 RUN or HOLD with pause=1: go to or stay in HOLD; q held; no terminal detection.
REQ-020 HOLD with pause=0: go to RUN; counting resumes at the next edge.
REQ-021 FIN: q held; go to IDLE at next edge.
REQ-022 Latency: start-accept edge to done-setting edge = ((term_val - start_val) mod 2^N) + 2 edges, plus one edge per cycle spent in HOLD.
REQ-023 start_val == term_val: terminal event on first RUN cycle; done set 2 edges after start acceptance.
REQ-024 Periodic period = ((term_val - start_val) mod 2^N) + 2 cycles; q holds term_val during the LOAD cycle.
REQ-025 abort=1 in any non-IDLE state: go to IDLE at next edge; q held; no done; period_cnt held. abort has priority over pause, start and terminal event.
REQ-026 start while busy=1 SHALL be ignored; start and abort both high in IDLE: stay IDLE.
REQ-027 Inputs start_val, term_val and mode changing while busy SHALL have no effect on the active run.

Reset
REQ-028 reset=0 at a rising edge: state IDLE, q=0, busy=0, done=0, period_cnt=0, latched mode/start_val/term_val = 0; reset overrides all other inputs.
REQ-029 Reset asserted mid-run SHALL abandon the run without a done pulse.

Structure
REQ-030 FSM state encoding and the width constant N default SHALL live in a shared package counter_pkg.
REQ-031 The count datapath SHALL be one instance of the team's existing Counter block, used as a sub-module; its load/en are driven by counter_ctrl. load has priority over en. The Counter reset is driven from the inverted reset.
REQ-032 The FSM, latches, done and period_cnt registers SHALL reside in counter_ctrl; no combinational path from inputs to done.

Verification
REQ-033 Reset: reset=0 for 2 cycles with start=1 -> q=0, busy=0, done=0, period_cnt=0.
REQ-034 One-shot start_val=1010, term_val=1101 -> q 1010,1011,1100,1101; done high exactly 5 edges after start accept; busy low after FIN; period_cnt=1.
REQ-035 Wrap: start_val=1110, term_val=0001 -> q 1110,1111,0000,0001; done at edge 5.
REQ-036 Periodic start_val=2, term_val=4 -> q 2,3,4,4,2,3,4,4...; done every 4 cycles; period_cnt 1,2,3...
REQ-037 Pause: start_val=0, term_val=15, pause high 3 cycles at q=5 -> q holds 5; done at edge 20 instead of 17.
REQ-038 Abort at q=7 -> busy low next edge, q stays 7, no done; start pulsed while busy ignored; start_val==term_val gives done at edge 2.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter controller.
// FSM encoding, width default and the saturating event-count helper.
package counter_pkg;

  localparam int N_DEF = 4;
  localparam int PCW   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_HOLD,
    S_FIN
  } state_e;

  function automatic logic [PCW-1:0] sat_inc(
    input logic [PCW-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Control/status bundle between a requester and counter_ctrl.
// master drives requests, slave is the controller side.
interface counter_ctrl_if
  import counter_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic           start;
  logic           mode;
  logic [N-1:0]   start_val;
  logic [N-1:0]   term_val;
  logic           pause;
  logic           abort;
  logic [N-1:0]   q;
  logic           busy;
  logic           done;
  logic [PCW-1:0] period_cnt;

  modport master (
    output start, mode, start_val, term_val,
    output pause, abort,
    input  q, busy, done, period_cnt
  );

  modport slave (
    input  start, mode, start_val, term_val,
    input  pause, abort,
    output q, busy, done, period_cnt
  );

endinterface

// File: rtl/counter_ctrl_counter.sv
// Loadable up-counter, wraps modulo 2^N.
// Synchronous active-high reset; load wins over enable.
module counter_ctrl_counter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (en_i) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run controller around a loadable counter: one-shot or
// periodic runs with pause, abort and terminal-event pulses.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic clk,
  input  logic reset,
  counter_ctrl_if.slave bus
);

  state_e         state_q, state_d;
  logic           mode_q, mode_d;
  logic [N-1:0]   sv_q, sv_d;
  logic [N-1:0]   tv_q, tv_d;
  logic           done_q, done_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic           load;
  logic           en;
  logic [N-1:0]   cnt;
  logic           term;

  counter_ctrl_counter #(
    .N (N)
  ) u_cnt (
    .clk_i  (clk),
    .rst_i  (~reset),
    .load_i (load),
    .en_i   (en),
    .d_i    (sv_q),
    .q_o    (cnt)
  );

  assign term = (cnt == tv_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sv_d    = sv_q;
    tv_d    = tv_q;
    done_d  = 1'b0;
    pc_d    = pc_q;
    load    = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          mode_d  = bus.mode;
          sv_d    = bus.start_val;
          tv_d    = bus.term_val;
          pc_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      // Leaving HOLD counts on the same edge, so each
      // HOLD cycle costs exactly one edge of latency.
      S_RUN, S_HOLD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.pause) begin
          state_d = S_HOLD;
        end else if (term) begin
          done_d  = 1'b1;
          pc_d    = sat_inc(pc_q);
          state_d = mode_q ? S_LOAD : S_FIN;
        end else begin
          en      = 1'b1;
          state_d = S_RUN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      sv_q    <= '0;
      tv_q    <= '0;
      done_q  <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sv_q    <= sv_d;
      tv_q    <= tv_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.q          = cnt;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.period_cnt = pc_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: done events are queued
// at launch and checked by an independent monitor.
module tb_counter_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  counter_ctrl_if #(.N(4)) bus();

  counter_ctrl #(.N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int q;
    int pc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && bus.done) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: done=1 at edge %0d, expected none",
                 cyc);
      end else begin
        e = sbq.pop_front();
        if (cyc != e.cyc || int'(bus.q) != e.q ||
            int'(bus.period_cnt) != e.pc) begin
          n_err++;
          $display("FAIL done_event: edge %0d q %0d pc %0d, expected edge %0d q %0d pc %0d",
                   cyc, bus.q, bus.period_cnt, e.cyc, e.q, e.pc);
        end
      end
    end
  end

  // Request a run, then scramble the latched inputs.
  task automatic launch(bit m, int sv, int tv, output int acc);
    bus.mode      = m;
    bus.start_val = 4'(sv);
    bus.term_val  = 4'(tv);
    bus.start     = 1'b1;
    tick();
    acc           = cyc;
    bus.start     = 1'b0;
    bus.mode      = ~m;
    bus.start_val = 4'(sv + 7);
    bus.term_val  = 4'(tv + 3);
  endtask

  task automatic oneshot(string nm, int sv, int tv);
    int a;
    int d;
    launch(1'b0, sv, tv, a);
    d = (tv - sv) & 15;
    sbq.push_back('{a + d + 2, tv, 1});
    for (int i = 0; i <= d; i++) begin
      tick();
      chk({nm, "_q"}, int'(bus.q), (sv + i) & 15);
    end
    tick();
    chk({nm, "_busy_fin"}, int'(bus.busy), 1);
    tick();
    chk({nm, "_busy_idle"}, int'(bus.busy), 0);
    chk({nm, "_pc"}, int'(bus.period_cnt), 1);
    chk({nm, "_q_held"}, int'(bus.q), tv);
  endtask

  initial begin
    int a;
    int pat[4];
    pat = '{2, 3, 4, 4};
    bus.start     = 1'b1;
    bus.mode      = 1'b1;
    bus.start_val = 4'd5;
    bus.term_val  = 4'd9;
    bus.pause     = 1'b0;
    bus.abort     = 1'b0;
    reset         = 1'b0;
    tick(2);
    chk("rst_q", int'(bus.q), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pc", int'(bus.period_cnt), 0);
    bus.start = 1'b0;
    reset     = 1'b1;
    mon_en    = 1'b1;
    tick();

    oneshot("os", 10, 13);
    oneshot("wrap", 14, 1);

    launch(1'b1, 2, 4, a);
    for (int k = 1; k <= 3; k++) begin
      sbq.push_back('{a + 4 * k, 4, k});
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("per_q", int'(bus.q), pat[(k - 1) % 4]);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("per_abort_busy", int'(bus.busy), 0);
    chk("per_abort_q", int'(bus.q), 4);
    chk("per_abort_pc", int'(bus.period_cnt), 3);
    tick(2);

    launch(1'b0, 0, 15, a);
    sbq.push_back('{a + 20, 15, 1});
    for (int i = 0; i <= 5; i++) begin
      tick();
      chk("pause_pre_q", int'(bus.q), i);
    end
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_hold_q", int'(bus.q), 5);
    end
    chk("pause_busy", int'(bus.busy), 1);
    bus.pause = 1'b0;
    tick();
    chk("pause_resume_q", int'(bus.q), 6);
    tick(9);
    chk("pause_term_q", int'(bus.q), 15);
    tick(2);
    chk("pause_idle", int'(bus.busy), 0);

    launch(1'b0, 5, 12, a);
    tick();
    chk("ab_q5", int'(bus.q), 5);
    bus.start     = 1'b1;
    bus.start_val = 4'd0;
    bus.term_val  = 4'd0;
    tick();
    bus.start = 1'b0;
    chk("ab_q6", int'(bus.q), 6);
    tick();
    chk("ab_q7", int'(bus.q), 7);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_busy", int'(bus.busy), 0);
    chk("ab_q_held", int'(bus.q), 7);
    tick(3);
    chk("ab_q_later", int'(bus.q), 7);
    chk("ab_pc", int'(bus.period_cnt), 0);
    chk("ab_busy_later", int'(bus.busy), 0);

    oneshot("eq", 9, 9);

    launch(1'b0, 0, 15, a);
    tick(4);
    reset = 1'b0;
    tick();
    chk("mrst_q", int'(bus.q), 0);
    chk("mrst_busy", int'(bus.busy), 0);
    chk("mrst_done", int'(bus.done), 0);
    chk("mrst_pc", int'(bus.period_cnt), 0);
    reset = 1'b1;
    tick(3);
    chk("mrst_idle", int'(bus.busy), 0);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    chk("sa_busy", int'(bus.busy), 0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
    chk("sa_busy2", int'(bus.busy), 0);

    tick(3);
    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
